// File: rtl/pdp8_pkg.sv
// Shared constants for the PDP-8 style register slices: word width and bus output modes.
package pdp8_pkg;

    localparam int PDP8_WORD        = 12;
    localparam int OUTMODE_TRISTATE = 1;
    localparam int OUTMODE_ORBUS    = 0;

endpackage : pdp8_pkg

// File: rtl/multilatch_reg_bus_driver.sv
// One output channel: shows the register value when enabled, otherwise releases
// the bus (high-Z) or drives zero so it can be OR-combined with other sources.
module bus_driver
    import pdp8_pkg::*;
#(
    parameter int WIDTH    = PDP8_WORD,
    parameter int TRISTATE = OUTMODE_TRISTATE
) (
    input  logic [WIDTH-1:0] value,
    input  logic             en,
    output wire [WIDTH-1:0]  chan
);

    generate
        if (TRISTATE == OUTMODE_TRISTATE) begin : g_tristate
            assign chan = en ? value : {WIDTH{1'bz}};
        end else begin : g_orbus
            assign chan = en ? value : {WIDTH{1'b0}};
        end
    endgenerate

endmodule : bus_driver

// File: rtl/multilatch_reg.sv
// Clocked multi-output register with clear / load / increment and a registered carry,
// feeding NOUT independently enabled bus channels.
module multilatch_reg
    import pdp8_pkg::*;
#(
    parameter int               WIDTH     = PDP8_WORD,
    parameter int               NOUT      = 2,
    parameter int               TRISTATE  = OUTMODE_TRISTATE,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      in,
    input  logic                  clear,
    input  logic                  latch,
    input  logic                  inc,
    input  logic [NOUT-1:0]       oe,
    output wire [NOUT*WIDTH-1:0]  out,
    output logic [WIDTH-1:0]      q,
    output logic                  carry
);

    logic [WIDTH-1:0] value_r;
    logic             carry_r;
    logic [WIDTH-1:0] operand_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] next_value_s;
    logic             next_carry_s;

    // Adder shared by load, load-and-increment and increment; a plain load adds zero.
    always_comb begin
        operand_s = value_r;
        if (latch) begin
            operand_s = in;
        end else begin
            operand_s = value_r;
        end
        sum_s = {1'b0, operand_s} + {{WIDTH{1'b0}}, inc};
    end

    // Per-cycle priority decode: clear beats latch, latch/inc share the adder, else hold.
    always_comb begin
        next_value_s = value_r;
        next_carry_s = carry_r;
        if (clear) begin
            next_value_s = {WIDTH{1'b0}};
            next_carry_s = 1'b0;
        end else if (latch || inc) begin
            next_value_s = sum_s[WIDTH-1:0];
            next_carry_s = sum_s[WIDTH];
        end else begin
            next_value_s = value_r;
            next_carry_s = carry_r;
        end
    end

    // Value and carry registers; reset wins immediately and drops any pending update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_r <= RESET_VAL;
            carry_r <= 1'b0;
        end else begin
            value_r <= next_value_s;
            carry_r <= next_carry_s;
        end
    end

    assign q     = value_r;
    assign carry = carry_r;

    generate
        for (genvar k = 0; k < NOUT; k++) begin : g_chan
            bus_driver #(
                .WIDTH    (WIDTH),
                .TRISTATE (TRISTATE)
            ) u_drv (
                .value (value_r),
                .en    (oe[k]),
                .chan  (out[k*WIDTH +: WIDTH])
            );
        end
    endgenerate

endmodule : multilatch_reg

// File: doc/multilatch_reg.md
Name: multilatch_reg

Overview:
- Clocked, parametrised successor to the 12-bit multi-output latch. Holds one WIDTH-bit value and drives it onto NOUT independently enabled bus outputs.
- Adds synchronous clear, load and increment, with a registered carry flag. Suitable for PC/MA/MQ-style registers that feed several internal buses.
- Output drive mode is selectable: tri-state for shared buses, or zero-when-disabled for OR-combined buses.

Parameters:
- WIDTH, 12, data width in bits (>=2)
- NOUT, 2, number of output channels (>=1)
- TRISTATE, 1, 1: disabled outputs are high-Z; 0: disabled outputs drive all-zero
- RESET_VAL, 0, register value after reset (WIDTH bits)

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high reset
- in  input  WIDTH  load data
- clear  input  1  synchronous clear request
- latch  input  1  synchronous load request
- inc  input  1  synchronous increment request
- oe  input  NOUT  per-channel output enable; bit k enables channel k
- out  output  NOUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- q  output  WIDTH  register value, always driven
- carry  output  1  registered carry-out of the last update

Behaviour:
- Reset (asynchronous, active-high):
  - value = RESET_VAL, carry = 0, immediately and independent of clk.
  - While reset is high, clear/latch/inc are ignored.
  - Reset asserted mid-operation discards any pending update.
- Update on each rising clk edge with reset low. Priority is evaluated in this order:
  - clear=1: value = 0, carry = 0. latch and inc are ignored.
  - latch=1, inc=0: value = in, carry = 0.
  - latch=1, inc=1: value = in + 1 (mod 2^WIDTH); carry = 1 iff in is all-ones. This is the load-and-increment path.
  - latch=0, inc=1: value = value + 1 (mod 2^WIDTH); carry = 1 iff the old value was all-ones. Wrap from all-ones gives 0.
  - none asserted: value and carry hold.
- Arithmetic: unsigned, computed at WIDTH+1 bits; the MSB of the sum is carry.
- Latency:
  - q, carry and enabled outputs reflect an update one edge after the request.
  - Outputs are combinational from the register and oe. No cycle delay on oe changes.
- Output channels:
  - oe[k]=1: channel k = value.
  - oe[k]=0: channel k = 'z' if TRISTATE=1, otherwise 0.
  - All channels may be enabled simultaneously; each shows the same value.
- q is always driven regardless of oe and TRISTATE.
- Requests are level-sensitive. Holding inc high for N cycles increments N times.
- No internal state machine beyond the value/carry registers. Mode selection is purely per-cycle priority decode.

Decomposition:
- Shared package pdp8_pkg:
  - localparam PDP8_WORD = 12
  - output-mode constants OUTMODE_TRISTATE = 1, OUTMODE_ORBUS = 0
- Sub-module bus_driver (WIDTH, TRISTATE):
  - one value, one enable, one channel output.
  - instantiated NOUT times via generate.
- The register/priority logic stays in multilatch_reg.

Test Plan:
- Default params. Reset pulse while in=12'h123 and latch=1, then release reset, latch=0, oe=2'b00 -> q=0, carry=0, out=all-Z; no load occurs during reset.
- in=12'h123, latch pulse one cycle; then oe=2'b01, then 2'b11 -> q=12'h123 after the edge; out[11:0]=12'h123 with out[23:12]=Z, then both channels 12'h123.
- Load 12'hFFE, inc held 3 cycles -> q goes FFF, 000, 001; carry 0, 1, 0.
- clear=1, latch=1, inc=1 together with in=12'h555, register at 12'h321 -> q=0, carry=0 after the edge.
- latch=1, inc=1 with in=12'hFFF -> q=12'h000, carry=1. Repeat with in=12'h07F -> q=12'h080, carry=0.
- TRISTATE=0, NOUT=3, WIDTH=8. Load 8'hA5, oe=3'b010 -> channel 1 = 8'hA5, channels 0 and 2 = 8'h00. Assert reset asynchronously mid-cycle -> q=RESET_VAL before the next edge.
